// File: rtl/i2s_sink.sv
// i2s_sink: oversampling I2S receiver.
// BCK, LRCK and SDATA are synchronized into the clk domain. Words are framed on
// the rising edge of BCK. Left/right pairs are pushed into a small FIFO and read
// out over a valid/ready stream. Sticky flags report dropped pairs and short words.
module i2s_sink #(
    parameter int Nb = 24,
    parameter int M  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              bck,
    input  logic              lrck,
    input  logic              sdata,
    output logic [2*Nb-1:0]   samples_data,
    output logic              samples_valid,
    input  logic              samples_ready,
    output logic [M:0]        count,
    output logic              overflow,
    output logic              frame_error,
    input  logic              error_clear
);

    localparam int              CW      = $clog2(Nb + 1);
    localparam int              DEPTH   = 1 << M;
    localparam logic [CW-1:0]   NB_C    = CW'(Nb);
    localparam logic [CW-1:0]   NB_M1_C = CW'(Nb - 1);
    localparam logic [CW-1:0]   ONE_C   = CW'(1);
    localparam logic [M:0]      DEPTH_C = (M + 1)'(DEPTH);

    // ------------------------------------------------------------------
    // Input synchronizers (bck has a third flop for edge detection)
    // ------------------------------------------------------------------
    logic [2:0] bck_sync_q;
    logic [1:0] lrck_sync_q;
    logic [1:0] sdata_sync_q;
    logic       bck_rise_s;
    logic       lrck_s;
    logic       sdata_s;

    // Shift the asynchronous pins through their synchronizer chains.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bck_sync_q   <= 3'b000;
            lrck_sync_q  <= 2'b00;
            sdata_sync_q <= 2'b00;
        end else begin
            bck_sync_q   <= {bck_sync_q[1:0], bck};
            lrck_sync_q  <= {lrck_sync_q[0], lrck};
            sdata_sync_q <= {sdata_sync_q[0], sdata};
        end
    end

    assign bck_rise_s = bck_sync_q[1] & ~bck_sync_q[2];
    assign lrck_s     = lrck_sync_q[1];
    assign sdata_s    = sdata_sync_q[1];

    // ------------------------------------------------------------------
    // Word framing and left/right pairing
    // ------------------------------------------------------------------
    // word_q holds the first Nb-1 bits; the final bit comes straight from sdata_s.
    logic [CW-1:0]   bit_cnt_q,   bit_cnt_d;
    logic            lrck_prev_q, lrck_prev_d;
    logic            have_left_q, have_left_d;
    logic [Nb-2:0]   word_q,      word_d;
    logic [Nb-1:0]   left_hold_q, left_hold_d;
    logic [Nb-1:0]   word_full_s;
    logic            push_s;
    logic            frame_evt_s;

    assign word_full_s = {word_q, sdata_s};

    // Framing state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt_q   <= {CW{1'b0}};
            lrck_prev_q <= 1'b0;
            have_left_q <= 1'b0;
            word_q      <= {(Nb-1){1'b0}};
            left_hold_q <= {Nb{1'b0}};
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            lrck_prev_q <= lrck_prev_d;
            have_left_q <= have_left_d;
            word_q      <= word_d;
            left_hold_q <= left_hold_d;
        end
    end

    // Next-state for framing: boundary detect, MSB-first shift, word completion.
    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        lrck_prev_d = lrck_prev_q;
        have_left_d = have_left_q;
        word_d      = word_q;
        left_hold_d = left_hold_q;
        push_s      = 1'b0;
        frame_evt_s = 1'b0;
        if (!enable) begin
            // Idle: ignore bits until a real LRCK transition after re-enable.
            bit_cnt_d   = NB_C;
            have_left_d = 1'b0;
            word_d      = {(Nb-1){1'b0}};
            lrck_prev_d = lrck_s;
        end else if (bck_rise_s) begin
            if (lrck_s != lrck_prev_q) begin
                // Word boundary; this edge carries the I2S delay slot.
                if ((bit_cnt_q != {CW{1'b0}}) && (bit_cnt_q < NB_C)) begin
                    frame_evt_s = 1'b1;
                    have_left_d = 1'b0;
                end else begin
                    frame_evt_s = 1'b0;
                end
                bit_cnt_d   = {CW{1'b0}};
                lrck_prev_d = lrck_s;
                word_d      = {(Nb-1){1'b0}};
            end else if (bit_cnt_q < NB_C) begin
                word_d    = word_full_s[Nb-2:0];
                bit_cnt_d = bit_cnt_q + ONE_C;
                if (bit_cnt_q == NB_M1_C) begin
                    if (!lrck_s) begin
                        left_hold_d = word_full_s;
                        have_left_d = 1'b1;
                    end else if (have_left_q) begin
                        push_s      = 1'b1;
                        have_left_d = 1'b0;
                    end else begin
                        // Unpaired right word is dropped.
                        have_left_d = 1'b0;
                    end
                end else begin
                    have_left_d = have_left_q;
                end
            end else begin
                // Slot padding beyond Nb bits.
                bit_cnt_d = NB_C;
            end
        end else begin
            bit_cnt_d = bit_cnt_q;
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    logic [2*Nb-1:0] mem_q [DEPTH];
    logic [M-1:0]    wr_ptr_q, wr_ptr_d;
    logic [M-1:0]    rd_ptr_q, rd_ptr_d;
    logic [M:0]      count_q,  count_d;
    logic            pop_s;
    logic            full_s;
    logic            do_push_s;
    logic            ovf_evt_s;

    // Push/pop decisions and pointer/occupancy next-state.
    always_comb begin
        pop_s     = (count_q != {(M+1){1'b0}}) && samples_ready;
        full_s    = (count_q == DEPTH_C);
        do_push_s = push_s && (!full_s || pop_s);
        ovf_evt_s = push_s && full_s && !pop_s;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + M'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + M'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        count_d = count_q + {{M{1'b0}}, do_push_s} - {{M{1'b0}}, pop_s};
    end

    // FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {(2*Nb){1'b0}};
            end
            wr_ptr_q <= {M{1'b0}};
            rd_ptr_q <= {M{1'b0}};
            count_q  <= {(M+1){1'b0}};
        end else begin
            if (do_push_s) begin
                mem_q[wr_ptr_q] <= {left_hold_q, word_full_s};
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // ------------------------------------------------------------------
    // Sticky error flags (a set on the same edge beats error_clear)
    // ------------------------------------------------------------------
    logic overflow_q, overflow_d;
    logic frame_err_q, frame_err_d;

    // Flag next-state: clear on request, set on event.
    always_comb begin
        overflow_d  = (error_clear ? 1'b0 : overflow_q)  | ovf_evt_s;
        frame_err_d = (error_clear ? 1'b0 : frame_err_q) | frame_evt_s;
    end

    // Flag registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign samples_data  = mem_q[rd_ptr_q];
    assign samples_valid = (count_q != {(M+1){1'b0}});
    assign count         = count_q;
    assign overflow      = overflow_q;
    assign frame_error   = frame_err_q;

endmodule

// File: tb/tb_i2s_sink.sv
// Directed testbench for i2s_sink: drives an I2S bit stream (BCK = clk/8,
// 32-bit slots, 24-bit words) and checks pairs, occupancy and error flags.
module tb_i2s_sink;

    localparam int NB = 24;

    logic            clk = 1'b0;
    logic            reset;
    logic            enable;
    logic            bck;
    logic            lrck;
    logic            sdata;
    logic [2*NB-1:0] samples_data;
    logic            samples_valid;
    logic            samples_ready;
    logic [1:0]      count;
    logic            overflow;
    logic            frame_error;
    logic            error_clear;

    int n_tests = 0;
    int n_fail  = 0;

    logic [2*NB-1:0] got_q [$];
    int              max_cnt;
    bit              mon_en = 1'b0;

    always #5 clk = ~clk;

    i2s_sink #(.Nb(NB), .M(1)) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .bck           (bck),
        .lrck          (lrck),
        .sdata         (sdata),
        .samples_data  (samples_data),
        .samples_valid (samples_valid),
        .samples_ready (samples_ready),
        .count         (count),
        .overflow      (overflow),
        .frame_error   (frame_error),
        .error_clear   (error_clear)
    );

    // Record popped pairs and peak occupancy while the stream test runs.
    always @(negedge clk) begin
        if (mon_en) begin
            if (samples_valid && samples_ready) got_q.push_back(samples_data);
            if (int'(count) > max_cnt) max_cnt = int'(count);
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One BCK period: data/LRCK change while BCK is low, sampled on the rise.
    task automatic send_bit(input logic l, input logic d);
        bck = 1'b0; lrck = l; sdata = d;
        #40;
        bck = 1'b1;
        #40;
    endtask

    // Delay slot followed by the first nbits of w, MSB first.
    task automatic send_data(input logic l, input logic [NB-1:0] w, input int nbits);
        send_bit(l, 1'b0);
        for (int i = 0; i < nbits; i++) send_bit(l, w[NB-1-i]);
    endtask

    task automatic send_pad(input logic l, input int n);
        for (int i = 0; i < n; i++) send_bit(l, 1'b0);
    endtask

    task automatic send_frame(input logic [NB-1:0] lw, input logic [NB-1:0] rw);
        send_data(1'b0, lw, NB);
        send_pad(1'b0, 7);
        send_data(1'b1, rw, NB);
        send_pad(1'b1, 7);
    endtask

    task automatic pop_one();
        @(negedge clk) samples_ready = 1'b1;
        @(negedge clk) samples_ready = 1'b0;
    endtask

    task automatic clear_errors();
        @(negedge clk) error_clear = 1'b1;
        @(negedge clk) error_clear = 1'b0;
    endtask

    logic [NB-1:0] rw;
    logic [NB-1:0] nn;
    bit            found;

    initial begin
        reset = 1'b0; enable = 1'b0; bck = 1'b0; lrck = 1'b1; sdata = 1'b0;
        samples_ready = 1'b0; error_clear = 1'b0;
        #22;
        check_eq("rst_valid", samples_valid, 1'b0);
        check_eq("rst_data",  samples_data, 48'h0);
        check_eq("rst_count", count, 2'd0);
        check_eq("rst_ovf",   overflow, 1'b0);
        check_eq("rst_ferr",  frame_error, 1'b0);
        #20 reset = 1'b1;
        #50 enable = 1'b1;
        #20;

        // Nominal pair with latency check on the last right bit.
        send_data(1'b0, 24'hABCDEF, NB);
        send_pad(1'b0, 7);
        rw = 24'h123456;
        send_bit(1'b1, 1'b0);
        for (int i = 0; i < NB-1; i++) send_bit(1'b1, rw[NB-1-i]);
        bck = 1'b0; sdata = rw[0];
        #40;
        check_eq("nom_valid_before_lsb", samples_valid, 1'b0);
        bck = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #10;
            if (samples_valid) found = 1'b1;
        end
        check_eq("nom_latency", found, 1'b1);
        send_pad(1'b1, 7);
        check_eq("nom_data",  samples_data, 48'hABCDEF123456);
        check_eq("nom_count", count, 2'd1);
        pop_one();
        check_eq("nom_count_after_pop", count, 2'd0);
        check_eq("nom_valid_after_pop", samples_valid, 1'b0);

        // Stream of 4 pairs with ready held high.
        max_cnt = 0;
        samples_ready = 1'b1;
        mon_en = 1'b1;
        for (int n = 1; n <= 4; n++) begin
            nn = NB'(n);
            send_frame(nn, ~nn);
        end
        #100;
        mon_en = 1'b0;
        samples_ready = 1'b0;
        check_eq("stream_pops", got_q.size(), 4);
        for (int n = 1; n <= 4; n++) begin
            nn = NB'(n);
            if (got_q.size() > 0) check_eq($sformatf("stream_pair%0d", n), got_q.pop_front(), {nn, ~nn});
        end
        check_eq("stream_max_count", max_cnt, 1);
        check_eq("stream_ovf",  overflow, 1'b0);
        check_eq("stream_ferr", frame_error, 1'b0);

        // Overflow: three pairs with ready low.
        send_frame(24'h111111, 24'h222222);
        send_frame(24'h333333, 24'h444444);
        send_frame(24'h555555, 24'h666666);
        check_eq("ovf_count", count, 2'd2);
        check_eq("ovf_flag",  overflow, 1'b1);
        check_eq("ovf_head",  samples_data, 48'h111111222222);
        clear_errors();
        check_eq("ovf_cleared",       overflow, 1'b0);
        check_eq("ovf_count_kept",    count, 2'd2);
        check_eq("ovf_head_kept",     samples_data, 48'h111111222222);
        pop_one();
        check_eq("ovf_second",        samples_data, 48'h333333444444);
        pop_one();
        check_eq("ovf_drained",       count, 2'd0);

        // Short left word: frame dropped, flag set, next frame clean.
        send_data(1'b0, 24'hFFFFFF, 10);
        send_data(1'b1, 24'h654321, NB);
        send_pad(1'b1, 7);
        check_eq("short_ferr",  frame_error, 1'b1);
        check_eq("short_count", count, 2'd0);
        clear_errors();
        check_eq("short_ferr_cleared", frame_error, 1'b0);
        send_frame(24'hC0FFEE, 24'h0BEEF0);
        check_eq("short_next_count", count, 2'd1);
        check_eq("short_next_data",  samples_data, 48'hC0FFEE0BEEF0);
        check_eq("short_next_ferr",  frame_error, 1'b0);
        pop_one();

        // Reset mid-right-word with one pair buffered; release while lrck=1.
        send_frame(24'hA1A2A3, 24'hB1B2B3);
        check_eq("mid_pre_count", count, 2'd1);
        send_data(1'b0, 24'h0F0F0F, NB);
        send_pad(1'b0, 7);
        send_data(1'b1, 24'h707070, 10);
        #3 reset = 1'b0;
        #1;
        check_eq("mid_rst_valid", samples_valid, 1'b0);
        check_eq("mid_rst_count", count, 2'd0);
        send_pad(1'b1, 4);
        bck = 1'b0;
        #20 reset = 1'b1;
        #20;
        send_pad(1'b1, 17);
        check_eq("startup_no_unpaired", count, 2'd0);
        send_frame(24'h13579B, 24'h2468AC);
        check_eq("startup_count", count, 2'd1);
        check_eq("startup_data",  samples_data, 48'h13579B2468AC);
        pop_one();
        check_eq("startup_drained", count, 2'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
